// File: rtl/queue_dispatcher_if.sv
// Signal bundle between the arrival/desk-done buttons, the ticket dispatcher
// and the display logic. The dispatcher takes the slave side.
interface queue_dispatcher_if #(
    parameter int NUM_DESKS = 4,
    parameter int TICKET_W  = 8
);
    localparam int DESK_W = $clog2(NUM_DESKS);

    logic                 new_client;
    logic                 new_priority;
    logic [NUM_DESKS-1:0] desk_done;
    logic                 issue_valid;
    logic [TICKET_W-1:0]  issue_ticket;
    logic                 issue_priority;
    logic                 reject;
    logic                 assign_valid;
    logic [DESK_W-1:0]    assign_desk;
    logic [TICKET_W-1:0]  assign_ticket;
    logic                 assign_priority;
    logic [TICKET_W-1:0]  waiting_normal;
    logic [TICKET_W-1:0]  waiting_priority;
    logic [NUM_DESKS-1:0] desk_busy;
    logic                 full;

    modport master (
        output new_client, new_priority, desk_done,
        input  issue_valid, issue_ticket, issue_priority, reject,
        input  assign_valid, assign_desk, assign_ticket, assign_priority,
        input  waiting_normal, waiting_priority, desk_busy, full
    );

    modport slave (
        input  new_client, new_priority, desk_done,
        output issue_valid, issue_ticket, issue_priority, reject,
        output assign_valid, assign_desk, assign_ticket, assign_priority,
        output waiting_normal, waiting_priority, desk_busy, full
    );
endinterface

// File: rtl/queue_dispatcher.sv
// Client ticket dispatcher: issues normal/priority tickets, counts waiting clients
// and hands tickets to free desks round-robin, priority first with a starvation guard.
module queue_dispatcher #(
    parameter int NUM_DESKS   = 4,
    parameter int TICKET_W    = 8,
    parameter int MAX_CLIENTS = 100,
    parameter int PRIO_BURST  = 3
) (
    input  logic              clk,
    input  logic              rst,
    queue_dispatcher_if.slave bus
);
    localparam int DESK_W  = $clog2(NUM_DESKS);
    localparam int BURST_W = $clog2(PRIO_BURST + 1);

    localparam logic [DESK_W-1:0]    LAST_DESK  = DESK_W'(NUM_DESKS - 1);
    localparam logic [DESK_W-1:0]    DESK_ONE   = DESK_W'(1);
    localparam logic [NUM_DESKS-1:0] DESK_BIT0  = NUM_DESKS'(1);
    localparam logic [TICKET_W-1:0]  TICKET_ONE = TICKET_W'(1);
    localparam logic [TICKET_W:0]    MAX_TOTAL  = (TICKET_W + 1)'(MAX_CLIENTS);
    localparam logic [TICKET_W:0]    TOTAL_TWO  = (TICKET_W + 1)'(2);
    localparam logic [BURST_W-1:0]   BURST_MAX  = BURST_W'(PRIO_BURST);
    localparam logic [BURST_W-1:0]   BURST_ONE  = BURST_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } state_t;

    // Ticket numbers skip 0: after the all-ones value the sequence restarts at 1.
    function automatic logic [TICKET_W-1:0] next_ticket(input logic [TICKET_W-1:0] t);
        if (t == {TICKET_W{1'b1}}) begin
            return TICKET_ONE;
        end else begin
            return t + TICKET_ONE;
        end
    endfunction

    state_t               state_r, state_nxt_s;
    logic [TICKET_W-1:0]  wait_n_r, wait_p_r, wait_n_nxt_s, wait_p_nxt_s;
    logic [TICKET_W-1:0]  issue_n_r, issue_p_r, serve_n_r, serve_p_r;
    logic [NUM_DESKS-1:0] busy_r, busy_nxt_s;
    logic [DESK_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [BURST_W-1:0]   burst_r, burst_nxt_s;

    logic                 issue_valid_r, issue_priority_r, reject_r, full_r;
    logic [TICKET_W-1:0]  issue_ticket_r, assign_ticket_r;
    logic                 assign_valid_r, assign_priority_r;
    logic [DESK_W-1:0]    assign_desk_r;

    logic [TICKET_W:0]    total_s, total_nxt_s;
    logic                 acc_n_s, acc_p_s, work_s;
    logic                 disp_s, disp_prio_s, disp_n_s, disp_p_s;
    logic [NUM_DESKS-1:0] free_hi_s, search_s;
    logic [DESK_W-1:0]    pick_s;

    assign total_s     = {1'b0, wait_n_r} + {1'b0, wait_p_r};
    assign work_s      = (busy_r != {NUM_DESKS{1'b1}}) && (total_s != '0);
    assign disp_prio_s = (wait_p_r != '0) && !((burst_r == BURST_MAX) && (wait_n_r != '0));
    assign disp_p_s    = disp_s & disp_prio_s;
    assign disp_n_s    = disp_s & ~disp_prio_s;

    // Admission: capacity is judged on the count registered before this cycle.
    always_comb begin
        acc_p_s = 1'b0;
        acc_n_s = 1'b0;
        if (total_s < MAX_TOTAL) begin
            acc_p_s = bus.new_priority;
            if (bus.new_priority) begin
                acc_n_s = bus.new_client && ((MAX_TOTAL - total_s) >= TOTAL_TWO);
            end else begin
                acc_n_s = bus.new_client;
            end
        end else begin
            acc_p_s = 1'b0;
            acc_n_s = 1'b0;
        end
    end

    // Round-robin search: lowest free desk at/after the pointer, else lowest free desk below it.
    always_comb begin
        free_hi_s = '0;
        pick_s    = '0;
        for (int i = 0; i < NUM_DESKS; i++) begin
            free_hi_s[i] = ~busy_r[i] & (DESK_W'(i) >= rr_ptr_r);
        end
        search_s = (|free_hi_s) ? free_hi_s : (~busy_r & ~free_hi_s);
        for (int i = NUM_DESKS - 1; i >= 0; i--) begin
            pick_s = search_s[i] ? DESK_W'(i) : pick_s;
        end
    end

    // Dispatch FSM next-state: tickets are only handed out while in DISPATCH.
    always_comb begin
        state_nxt_s = state_r;
        disp_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (work_s) begin
                    state_nxt_s = ST_DISPATCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (work_s) begin
                    disp_s      = 1'b1;
                    state_nxt_s = ST_DISPATCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of counts, desk occupancy, pointer and priority burst counter.
    always_comb begin
        wait_n_nxt_s = wait_n_r + TICKET_W'(acc_n_s) - TICKET_W'(disp_n_s);
        wait_p_nxt_s = wait_p_r + TICKET_W'(acc_p_s) - TICKET_W'(disp_p_s);
        total_nxt_s  = {1'b0, wait_n_nxt_s} + {1'b0, wait_p_nxt_s};
        busy_nxt_s   = (busy_r & ~bus.desk_done) | (disp_s ? (DESK_BIT0 << pick_s) : '0);
        if (disp_s) begin
            rr_ptr_nxt_s = (pick_s == LAST_DESK) ? '0 : pick_s + DESK_ONE;
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
        if (wait_n_r == '0) begin
            burst_nxt_s = '0;
        end else if (disp_n_s) begin
            burst_nxt_s = '0;
        end else if (disp_p_s && (burst_r != BURST_MAX)) begin
            burst_nxt_s = burst_r + BURST_ONE;
        end else begin
            burst_nxt_s = burst_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_n_r          <= '0;
            wait_p_r          <= '0;
            issue_n_r         <= TICKET_ONE;
            issue_p_r         <= TICKET_ONE;
            serve_n_r         <= TICKET_ONE;
            serve_p_r         <= TICKET_ONE;
            busy_r            <= '0;
            rr_ptr_r          <= '0;
            burst_r           <= '0;
            issue_valid_r     <= 1'b0;
            issue_ticket_r    <= '0;
            issue_priority_r  <= 1'b0;
            reject_r          <= 1'b0;
            assign_valid_r    <= 1'b0;
            assign_desk_r     <= '0;
            assign_ticket_r   <= '0;
            assign_priority_r <= 1'b0;
            full_r            <= 1'b0;
        end else begin
            wait_n_r          <= wait_n_nxt_s;
            wait_p_r          <= wait_p_nxt_s;
            issue_n_r         <= acc_n_s ? next_ticket(issue_n_r) : issue_n_r;
            issue_p_r         <= acc_p_s ? next_ticket(issue_p_r) : issue_p_r;
            serve_n_r         <= disp_n_s ? next_ticket(serve_n_r) : serve_n_r;
            serve_p_r         <= disp_p_s ? next_ticket(serve_p_r) : serve_p_r;
            busy_r            <= busy_nxt_s;
            rr_ptr_r          <= rr_ptr_nxt_s;
            burst_r           <= burst_nxt_s;
            issue_valid_r     <= acc_p_s | acc_n_s;
            issue_ticket_r    <= acc_p_s ? issue_p_r : (acc_n_s ? issue_n_r : '0);
            issue_priority_r  <= acc_p_s;
            reject_r          <= (bus.new_client & ~acc_n_s) | (bus.new_priority & ~acc_p_s);
            assign_valid_r    <= disp_s;
            assign_desk_r     <= disp_s ? pick_s : '0;
            assign_ticket_r   <= disp_p_s ? serve_p_r : (disp_n_s ? serve_n_r : '0);
            assign_priority_r <= disp_p_s;
            full_r            <= (total_nxt_s == MAX_TOTAL);
        end
    end

    assign bus.issue_valid      = issue_valid_r;
    assign bus.issue_ticket     = issue_ticket_r;
    assign bus.issue_priority   = issue_priority_r;
    assign bus.reject           = reject_r;
    assign bus.assign_valid     = assign_valid_r;
    assign bus.assign_desk      = assign_desk_r;
    assign bus.assign_ticket    = assign_ticket_r;
    assign bus.assign_priority  = assign_priority_r;
    assign bus.waiting_normal   = wait_n_r;
    assign bus.waiting_priority = wait_p_r;
    assign bus.desk_busy        = busy_r;
    assign bus.full             = full_r;
endmodule

// File: tb/tb_queue_dispatcher.sv
// Bench for queue_dispatcher: directed arrival/desk sequences, expected tickets queued
// at stimulus time and compared by a negedge monitor whenever the DUT reports an event.
module tb_queue_dispatcher;
    localparam int ND = 4;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    typedef struct packed {
        logic [TW-1:0] ticket;
        logic          prio;
    } issue_t;

    typedef struct packed {
        logic [1:0]    desk;
        logic [TW-1:0] ticket;
        logic          prio;
    } assign_t;

    issue_t  exp_issue[$];
    assign_t exp_assign[$];

    int burst_tk [10] = '{1, 2, 3, 5, 4, 5, 6, 6, 7, 8};
    bit burst_pr [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    queue_dispatcher_if #(.NUM_DESKS(ND), .TICKET_W(TW)) bus ();

    queue_dispatcher #(
        .NUM_DESKS  (ND),
        .TICKET_W   (TW),
        .MAX_CLIENTS(100),
        .PRIO_BURST (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_issue(input int t, input bit p);
        issue_t e;
        e.ticket = TW'(t);
        e.prio   = p;
        exp_issue.push_back(e);
    endtask

    task automatic push_assign(input int d, input int t, input bit p);
        assign_t e;
        e.desk   = 2'(d);
        e.ticket = TW'(t);
        e.prio   = p;
        exp_assign.push_back(e);
    endtask

    task automatic arrive(input logic n, input logic p);
        bus.new_client   = n;
        bus.new_priority = p;
        tick();
        bus.new_client   = 1'b0;
        bus.new_priority = 1'b0;
    endtask

    task automatic wait_assign(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (bus.assign_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no assign within 12 cycles, expected one", name);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int c = 0;
        while ((exp_issue.size() != 0 || exp_assign.size() != 0) && c < limit) begin
            tick();
            c++;
        end
        check(name, 32'(exp_issue.size() + exp_assign.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_issue_valid"},  32'(bus.issue_valid), 32'd0);
        check({tag, "_issue_ticket"}, 32'(bus.issue_ticket), 32'd0);
        check({tag, "_issue_prio"},   32'(bus.issue_priority), 32'd0);
        check({tag, "_reject"},       32'(bus.reject), 32'd0);
        check({tag, "_assign_valid"}, 32'(bus.assign_valid), 32'd0);
        check({tag, "_assign_desk"},  32'(bus.assign_desk), 32'd0);
        check({tag, "_assign_ticket"},32'(bus.assign_ticket), 32'd0);
        check({tag, "_assign_prio"},  32'(bus.assign_priority), 32'd0);
        check({tag, "_wait_normal"},  32'(bus.waiting_normal), 32'd0);
        check({tag, "_wait_prio"},    32'(bus.waiting_priority), 32'd0);
        check({tag, "_desk_busy"},    32'(bus.desk_busy), 32'd0);
        check({tag, "_full"},         32'(bus.full), 32'd0);
    endtask

    // Scoreboard monitor: every reported issue/assign must match the oldest expectation.
    always @(negedge clk) begin
        issue_t  ei;
        assign_t ea;
        if (bus.issue_valid === 1'b1) begin
            vectors++;
            if (exp_issue.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected: got ticket %0d prio %0d expected no issue",
                         bus.issue_ticket, bus.issue_priority);
            end else begin
                ei = exp_issue.pop_front();
                if (bus.issue_ticket !== ei.ticket || bus.issue_priority !== ei.prio) begin
                    miscompares++;
                    $display("FAIL issue: got ticket %0d prio %0d expected ticket %0d prio %0d",
                             bus.issue_ticket, bus.issue_priority, ei.ticket, ei.prio);
                end
            end
        end
        if (bus.assign_valid === 1'b1) begin
            vectors++;
            if (exp_assign.size() == 0) begin
                miscompares++;
                $display("FAIL assign_unexpected: got desk %0d ticket %0d prio %0d expected no assign",
                         bus.assign_desk, bus.assign_ticket, bus.assign_priority);
            end else begin
                ea = exp_assign.pop_front();
                if (bus.assign_desk !== ea.desk || bus.assign_ticket !== ea.ticket ||
                    bus.assign_priority !== ea.prio) begin
                    miscompares++;
                    $display("FAIL assign: got desk %0d ticket %0d prio %0d expected desk %0d ticket %0d prio %0d",
                             bus.assign_desk, bus.assign_ticket, bus.assign_priority,
                             ea.desk, ea.ticket, ea.prio);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.new_client   = 1'b0;
        bus.new_priority = 1'b0;
        bus.desk_done    = '0;
        rst = 1'b1;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;

        // Five normal arrivals with all desks free: desks 0..3 take tickets 1..4.
        for (int k = 1; k <= 5; k++) begin
            push_issue(k, 1'b0);
            if (k <= 4) push_assign(k - 1, k, 1'b0);
            arrive(1'b1, 1'b0);
        end
        wait_drain("rr_fill_drain", 30);
        repeat (4) tick();
        check("rr_fill_wait_normal", 32'(bus.waiting_normal), 32'd1);
        check("rr_fill_desk_busy", 32'(bus.desk_busy), 32'hF);
        check("rr_fill_wait_prio", 32'(bus.waiting_priority), 32'd0);

        // All desks busy: new tickets only queue up.
        for (int k = 6; k <= 8; k++) begin
            push_issue(k, 1'b0);
            arrive(1'b1, 1'b0);
        end
        repeat (6) tick();
        check("busy_wait_normal", 32'(bus.waiting_normal), 32'd4);

        // Six priority tickets, then one desk cycled: P,P,P,N,P,P,P,N,N,N.
        for (int k = 1; k <= 6; k++) begin
            push_issue(k, 1'b1);
            arrive(1'b0, 1'b1);
        end
        check("prio_wait_prio", 32'(bus.waiting_priority), 32'd6);
        for (int i = 0; i < 10; i++) begin
            push_assign(0, burst_tk[i], burst_pr[i]);
            bus.desk_done = 4'b0001;
            tick();
            bus.desk_done = 4'b0000;
            wait_assign("burst_assign");
        end
        repeat (3) tick();
        check("burst_wait_normal", 32'(bus.waiting_normal), 32'd0);
        check("burst_wait_prio", 32'(bus.waiting_priority), 32'd0);
        check("burst_desk_busy", 32'(bus.desk_busy), 32'hF);

        // Fill to capacity with every desk busy, then two refused arrivals.
        for (int k = 0; k < 100; k++) begin
            push_issue(9 + k, 1'b0);
            arrive(1'b1, 1'b0);
        end
        check("cap_full", 32'(bus.full), 32'd1);
        check("cap_wait_normal", 32'(bus.waiting_normal), 32'd100);
        check("cap_reject_last_ok", 32'(bus.reject), 32'd0);
        for (int r = 0; r < 2; r++) begin
            arrive(1'b1, 1'b0);
            check("over_reject", 32'(bus.reject), 32'd1);
            check("over_wait_normal", 32'(bus.waiting_normal), 32'd100);
        end

        // One slot freed (99 waiting), then both arrivals in one cycle.
        push_assign(0, 9, 1'b0);
        bus.desk_done = 4'b0001;
        tick();
        bus.desk_done = 4'b0000;
        wait_assign("free_one_assign");
        repeat (2) tick();
        check("free_one_wait_normal", 32'(bus.waiting_normal), 32'd99);
        check("free_one_full", 32'(bus.full), 32'd0);
        push_issue(7, 1'b1);
        arrive(1'b1, 1'b1);
        check("both_reject", 32'(bus.reject), 32'd1);
        check("both_full", 32'(bus.full), 32'd1);
        check("both_wait_prio", 32'(bus.waiting_priority), 32'd1);
        check("both_wait_normal", 32'(bus.waiting_normal), 32'd99);
        wait_drain("both_drain", 5);

        // 300 normal tickets streamed through the desks: numbering wraps 255 -> 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            push_issue((k % 255) + 1, 1'b0);
            push_assign(k % 4, (k % 255) + 1, 1'b0);
            bus.new_client = 1'b1;
            bus.desk_done  = 4'hF;
            tick();
        end
        bus.new_client = 1'b0;
        wait_drain("wrap_drain", 50);
        bus.desk_done = 4'h0;
        repeat (2) tick();
        check("wrap_wait_normal", 32'(bus.waiting_normal), 32'd0);

        // Reset while tickets are flowing: everything drops the next cycle.
        for (int j = 0; j < 8; j++) begin
            push_issue(46 + j, 1'b0);
            push_assign(j % 4, 46 + j, 1'b0);
            bus.new_client = 1'b1;
            bus.desk_done  = 4'hF;
            tick();
        end
        rst = 1'b1;
        bus.new_client = 1'b0;
        bus.desk_done  = 4'h0;
        tick();
        check_zero_outputs("mid_reset");
        exp_issue.delete();
        exp_assign.delete();
        rst = 1'b0;
        tick();

        // Numbering restarts at 1 and the pointer at desk 0 after reset.
        push_issue(1, 1'b0);
        push_assign(0, 1, 1'b0);
        arrive(1'b1, 1'b0);
        wait_drain("restart_drain", 10);
        repeat (2) tick();
        check("restart_wait_normal", 32'(bus.waiting_normal), 32'd0);
        check("restart_desk_busy", 32'(bus.desk_busy), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
